// File: rtl/commul_pipe.sv
// Pipelined complex multiplier: (dir + j*dii) * W, W = exp(+/-j*2*pi*k/NPTS) from an elaborated ROM.
// Three stages with one global stall enable, round-half-up by CFRAC bits and output saturation.
module commul_pipe #(
  parameter int DW    = 36,
  parameter int FRAC  = 28,
  parameter int CW    = 18,
  parameter int CFRAC = 16,
  parameter int NPTS  = 32,
  parameter int TW    = $clog2(NPTS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          mode,
  input  logic [TW-1:0] twsel,
  input  logic [DW-1:0] dir,
  input  logic [DW-1:0] dii,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] dor,
  output logic [DW-1:0] doi,
  output logic          sat
);

  localparam int  PW = DW + CW + 1;
  localparam real PI = 3.14159265358979323846;

  localparam logic signed [PW-1:0] RND  = {{(PW-CFRAC){1'b0}}, 1'b1, {(CFRAC-1){1'b0}}};
  localparam logic signed [PW-1:0] MAXV = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  // An illegal parameter set (coefficient too narrow, data fraction too wide) lands here.
  if (CW < CFRAC + 2 || FRAC >= DW) begin : g_illegal_params
  end

  function automatic int round_away(input real x);
    if (x >= 0.0)
      return int'($floor(x + 0.5));
    else
      return -int'($floor(-x + 0.5));
  endfunction

  logic signed [CW-1:0] cos_rom [NPTS];
  logic signed [CW-1:0] sin_rom [NPTS];

  for (genvar gi = 0; gi < NPTS; gi++) begin : g_rom
    localparam real ANG = 2.0 * PI * real'(gi) / real'(NPTS);
    assign cos_rom[gi] = CW'(round_away($cos(ANG) * (2.0 ** CFRAC)));
    assign sin_rom[gi] = CW'(round_away($sin(ANG) * (2.0 ** CFRAC)));
  end

  // One enable stalls the whole pipe; bubbles advance like data.
  logic en;
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  logic signed [CW-1:0] s_sel;
  assign s_sel = mode ? -sin_rom[twsel] : sin_rom[twsel];

  // Stage 1: operands and coefficients (registered ROM read)
  logic                 v1_reg;
  logic signed [DW-1:0] dr_reg, di_reg;
  logic signed [CW-1:0] cr_reg, ci_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_reg <= 1'b0;
      dr_reg <= '0;
      di_reg <= '0;
      cr_reg <= '0;
      ci_reg <= '0;
    end else if (en) begin
      v1_reg <= in_valid;
      dr_reg <= $signed(dir);
      di_reg <= $signed(dii);
      cr_reg <= cos_rom[twsel];
      ci_reg <= s_sel;
    end
  end

  // Stage 2: the four partial products
  logic                       v2_reg;
  logic signed [DW+CW-1:0]    prr_reg, pii_reg, pri_reg, pir_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2_reg  <= 1'b0;
      prr_reg <= '0;
      pii_reg <= '0;
      pri_reg <= '0;
      pir_reg <= '0;
    end else if (en) begin
      v2_reg  <= v1_reg;
      prr_reg <= dr_reg * cr_reg;
      pii_reg <= di_reg * ci_reg;
      pri_reg <= dr_reg * ci_reg;
      pir_reg <= di_reg * cr_reg;
    end
  end

  // Stage 3: combine, round half up, clip
  logic signed [PW-1:0] re_full, im_full, re_rnd, im_rnd;
  logic [DW-1:0]        dor_next, doi_next;
  logic                 re_hi, re_lo, im_hi, im_lo;

  assign re_full = $signed({prr_reg[DW+CW-1], prr_reg}) - $signed({pii_reg[DW+CW-1], pii_reg});
  assign im_full = $signed({pri_reg[DW+CW-1], pri_reg}) + $signed({pir_reg[DW+CW-1], pir_reg});
  assign re_rnd  = (re_full + RND) >>> CFRAC;
  assign im_rnd  = (im_full + RND) >>> CFRAC;

  always_comb begin
    re_hi    = re_rnd > MAXV;
    re_lo    = re_rnd < MINV;
    im_hi    = im_rnd > MAXV;
    im_lo    = im_rnd < MINV;
    dor_next = re_rnd[DW-1:0];
    doi_next = im_rnd[DW-1:0];
    if (re_hi) dor_next = MAXV[DW-1:0];
    if (re_lo) dor_next = MINV[DW-1:0];
    if (im_hi) doi_next = MAXV[DW-1:0];
    if (im_lo) doi_next = MINV[DW-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      dor       <= '0;
      doi       <= '0;
      sat       <= 1'b0;
    end else if (en) begin
      out_valid <= v2_reg;
      if (v2_reg) begin
        dor <= dor_next;
        doi <= doi_next;
        sat <= re_hi | re_lo | im_hi | im_lo;
      end
    end
  end

endmodule

// File: tb/tb_commul_pipe.sv
// Scoreboard bench for commul_pipe: expectations queued on input handshake, compared on output handshake.
module tb_commul_pipe;
  localparam int DW = 36, FRAC = 28, CW = 18, CFRAC = 16, NPTS = 32, TW = 5;

  logic          clk = 1'b0, rst = 1'b0;
  logic          in_valid = 1'b0, in_ready, mode = 1'b0;
  logic [TW-1:0] twsel = '0;
  logic [DW-1:0] dir = '0, dii = '0, dor, doi;
  logic          out_valid, out_ready = 1'b0, sat;

  always #5 clk = ~clk;

  commul_pipe #(.DW(DW), .FRAC(FRAC), .CW(CW), .CFRAC(CFRAC), .NPTS(NPTS), .TW(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .twsel(twsel), .dir(dir), .dii(dii), .out_valid(out_valid), .out_ready(out_ready),
    .dor(dor), .doi(doi), .sat(sat)
  );

  typedef struct {
    logic [DW-1:0] r, i;
    logic          md;
    logic [TW-1:0] k;
    logic [DW-1:0] er, ei;
    logic          es;
    bit            lat;
  } stim_t;

  typedef struct {
    logic [DW-1:0] er, ei;
    logic          es;
    int            acc;
    bit            lat;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    checks = 0, errors = 0, cyc = 0, nout = 0;
  logic [DW-1:0] hold_r, hold_i;
  logic          hold_s;
  bit            stalled = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic longint rnd(input real x);
    if (x >= 0.0) return longint'($floor(x + 0.5));
    return -longint'($floor(-x + 0.5));
  endfunction

  // Reference: real-valued twiddle, 64-bit integer product, round half up, clip.
  function automatic stim_t mk(input logic [DW-1:0] r, input logic [DW-1:0] i, input logic md,
                               input int k, input bit lat);
    stim_t  s;
    real    a;
    longint c, sn, dr, di, re, im, lim;
    logic [63:0] rv, iv;
    bit     st;
    a   = 2.0 * 3.14159265358979323846 * real'(k) / real'(NPTS);
    c   = rnd($cos(a) * 65536.0);
    sn  = rnd($sin(a) * 65536.0);
    if (md) sn = -sn;
    dr  = longint'($signed(r));
    di  = longint'($signed(i));
    re  = (dr * c - di * sn + 64'sd32768) >>> 16;
    im  = (dr * sn + di * c + 64'sd32768) >>> 16;
    lim = 64'sd1 <<< (DW - 1);
    st  = 0;
    if (re > lim - 1) begin re = lim - 1; st = 1; end
    if (re < -lim)    begin re = -lim;    st = 1; end
    if (im > lim - 1) begin im = lim - 1; st = 1; end
    if (im < -lim)    begin im = -lim;    st = 1; end
    rv = re;
    iv = im;
    s.r = r; s.i = i; s.md = md; s.k = TW'(k);
    s.er = rv[DW-1:0]; s.ei = iv[DW-1:0]; s.es = st; s.lat = lat;
    return s;
  endfunction

  function automatic stim_t mkc(input logic [DW-1:0] r, input logic [DW-1:0] i, input logic md,
                                input int k, input logic [DW-1:0] er, input logic [DW-1:0] ei,
                                input logic es);
    stim_t s;
    s.r = r; s.i = i; s.md = md; s.k = TW'(k);
    s.er = er; s.ei = ei; s.es = es; s.lat = 1;
    return s;
  endfunction

  // One clock: drive at negedge, evaluate handshakes before the posedge.
  task automatic tick(input bit iv, input bit ordy);
    stim_t s;
    exp_t  e;
    in_valid = iv && (stim_q.size() > 0);
    if (in_valid) begin
      s = stim_q[0];
      dir = s.r; dii = s.i; mode = s.md; twsel = s.k;
    end
    out_ready = ordy;
    #1;
    check("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
    if (stalled) begin
      check("hold_dor", 64'(dor), 64'(hold_r));
      check("hold_doi", 64'(doi), 64'(hold_i));
      check("hold_sat", 64'(sat), 64'(hold_s));
    end
    stalled = out_valid && !out_ready;
    hold_r = dor; hold_i = doi; hold_s = sat;
    if (in_valid && in_ready) begin
      e.er = s.er; e.ei = s.ei; e.es = s.es; e.acc = cyc; e.lat = s.lat;
      exp_q.push_back(e);
      void'(stim_q.pop_front());
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("spurious_out", 64'(out_valid), 64'(0));
      else begin
        e = exp_q.pop_front();
        $display("OUT %0d cyc=%0d dor=%h doi=%h sat=%b", nout, cyc, dor, doi, sat);
        check("dor", 64'(dor), 64'(e.er));
        check("doi", 64'(doi), 64'(e.ei));
        check("sat", 64'(sat), 64'(e.es));
        if (e.lat) check("latency", 64'(cyc - e.acc), 64'(3));
        nout++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() > 0 || stim_q.size() > 0) && n < 300) begin
      tick(1, 1);
      n++;
    end
    if (n >= 300) check("drain_timeout", 64'(exp_q.size()), 64'(0));
  endtask

  localparam logic [DW-1:0] ONE  = 36'h010000000;
  localparam logic [DW-1:0] NEG1 = 36'hFF0000000;

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_dor", 64'(dor), 64'(0));
    check("rst_doi", 64'(doi), 64'(0));
    check("rst_sat", 64'(sat), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    rst = 1'b1;
    @(negedge clk);

    // Directed: identity, quarter turns, saturation, round-half-up
    stim_q.push_back(mkc(ONE, '0, 0, 0, ONE, '0, 0));
    stim_q.push_back(mkc(ONE, '0, 0, 8, '0, ONE, 0));
    stim_q.push_back(mkc(ONE, '0, 1, 8, '0, NEG1, 0));
    stim_q.push_back(mkc(36'h800000000, '0, 0, 16, 36'h7FFFFFFFF, '0, 1));
    stim_q.push_back(mkc(36'h000008000, '0, 0, 4, 36'h000005A83, 36'h000005A83, 0));
    stim_q.push_back(mkc(36'hFFFFF8000, '0, 0, 4, 36'hFFFFFA57E, 36'hFFFFFA57E, 0));
    drain();

    // Full twiddle sweep, back to back
    for (int k = 0; k < NPTS; k++) begin
      if (k == 4) stim_q.push_back(mkc(ONE, '0, 0, 4, 36'h00B505000, 36'h00B505000, 0));
      else        stim_q.push_back(mk(ONE, '0, 0, k, 1));
    end
    drain();

    // Back-pressure: out_ready low for four cycles starting at cycle 2
    for (int n = 0; n < 5; n++)
      stim_q.push_back(mk(DW'({$urandom(), $urandom()}), DW'({$urandom(), $urandom()}),
                          1'(n), n * 7 + 3, 0));
    for (int c = 0; c < 10; c++) tick(1, !(c >= 2 && c <= 5));
    drain();

    // Random traffic with random valid/ready, plus extreme operands
    stim_q.push_back(mk(36'h800000000, 36'h800000000, 0, 4, 0));
    stim_q.push_back(mk(36'h7FFFFFFFF, 36'h7FFFFFFFF, 0, 28, 0));
    stim_q.push_back(mk(36'h7FFFFFFFF, 36'h800000000, 1, 31, 0));
    for (int n = 0; n < 40; n++)
      stim_q.push_back(mk(DW'({$urandom(), $urandom()}), DW'({$urandom(), $urandom()}),
                          1'($urandom_range(0, 1)), int'($urandom_range(0, NPTS - 1)), 0));
    for (int c = 0; c < 120 && stim_q.size() > 0; c++)
      tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
    drain();

    // Reset mid-stream with two samples in flight
    stim_q.push_back(mk(ONE, ONE, 0, 5, 0));
    stim_q.push_back(mk(ONE, '0, 1, 9, 0));
    tick(1, 1);
    tick(1, 1);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_dor", 64'(dor), 64'(0));
    check("mid_rst_doi", 64'(doi), 64'(0));
    check("mid_rst_sat", 64'(sat), 64'(0));
    check("mid_rst_in_ready", 64'(in_ready), 64'(1));
    exp_q.delete();
    stim_q.delete();
    stalled = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick(0, 1);
      check("stale_valid", 64'(out_valid), 64'(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/commul_pipe.md
Name: commul_pipe

Overview:
- Parametrised successor to the single-rate twiddle complex multiplier used in the 32-point IFFT datapath.
- Multiplies a complex sample (dir + j·dii) by an internally generated twiddle W = exp(±j2πk/NPTS).
- Generalised point count, data and coefficient widths, and FFT/IFFT mode.
- Adds a 3-stage pipeline with valid/ready flow control, convergent-free round-half-up, saturation and a saturation flag.
- Sits between butterfly stages of the FFT/IFFT core.

Parameters:
- DW, 36, data width (two's complement, real and imaginary each).
- FRAC, 28, data fractional bits (informational; 1.0 = 2^FRAC).
- CW, 18, twiddle coefficient width (two's complement).
- CFRAC, 16, coefficient fractional bits (1.0 = 2^CFRAC; CW ≥ CFRAC+2).
- NPTS, 32, transform size; power of two, 4..1024.
- TW, $clog2(NPTS), twiddle index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept input this cycle.
- mode  in  1  0 = IFFT (W = exp(+j2πk/NPTS)), 1 = FFT (W = exp(−j2πk/NPTS)); sampled with the input.
- twsel  in  TW  twiddle index k.
- dir  in  DW  input real part.
- dii  in  DW  input imaginary part.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream accepts output.
- dor  out  DW  product real part.
- doi  out  DW  product imaginary part.
- sat  out  1  dor or doi was saturated for this output.

Behaviour:
- Reset (rst=0, asynchronous): all stage valids, out_valid, sat, dor and doi go to 0. in_ready is combinational and is 1 while in reset-release idle. Any in-flight data is discarded.
- Twiddle ROM: NPTS entries, built at elaboration.
  - c[k] = round(cos(2πk/NPTS)·2^CFRAC), s[k] = round(sin(2πk/NPTS)·2^CFRAC), rounding half away from zero.
  - Effective imaginary coefficient is +s[k] if mode=0 and −s[k] if mode=1.
  - Exact values at k=0, NPTS/4, NPTS/2 and 3NPTS/4 are ±2^CFRAC or 0.
- Flow control: single global enable en = ~out_valid | out_ready; in_ready = en.
  - Transfer occurs on in_valid & in_ready.
  - When en=0, every stage holds; no data is lost or duplicated; order is preserved.
  - Bubbles are not squeezed out.
- Stage 1 (on en): register dir, dii, the ROM coefficients and valid = in_valid.
- Stage 2 (on en): register four signed products dr·cr, di·ci, dr·ci, di·cr, each DW+CW bits.
- Stage 3 (on en): compute and register the outputs.
  - re = dr·cr − di·ci; im = dr·ci + di·cr, at DW+CW+1 bits.
  - Add 2^(CFRAC−1) and arithmetic-shift right by CFRAC (round half up).
  - Saturate to the DW-bit range [−2^(DW−1), 2^(DW−1)−1].
  - sat = 1 if either part clipped.
  - out_valid = stage-2 valid.
- Latency: an accepted input appears on dor/doi with out_valid exactly 3 cycles later when en stays 1. Throughput is 1 sample/cycle.
- Outputs hold their value while out_valid & ~out_ready.
- When out_valid=0, dor/doi/sat hold their last value (no requirement on content beyond reset value 0).
- twsel ≥ NPTS is impossible by width. All indices 0..NPTS−1 are legal, including wrap at NPTS−1 → 0 across successive inputs.
- Simultaneous out_ready=1 with a new in_valid while full: the output is consumed and the new input is accepted in the same cycle.

Test Plan (defaults: DW=36, CFRAC=16, NPTS=32):
- Reset: assert rst=0 mid-stream with 2 samples in flight, release → out_valid=0, dor=doi=sat=0, no stale output ever appears.
- Identity: dir=36'h10000000, dii=0, mode=0, twsel=0 → 3 cycles later dor=36'h10000000, doi=0, sat=0.
- Quarter-turn: same input, twsel=8.
  - mode=0 → dor=0, doi=268435456.
  - mode=1 → doi=−268435456.
- Sweep and rounding: same input, twsel 0..31 back-to-back, one per cycle, out_ready=1 → 32 consecutive outputs from cycle 3, each dor=c[k]·4096 and doi=s[k]·4096 (e.g. k=4: c=s=46341, dor=doi=189812736).
- Saturation: dir=−2^35, dii=0, twsel=16 (W=−1) → dor=2^35−1, doi=0, sat=1.
- Back-pressure: send 5 samples back-to-back with out_ready held 0 from cycle 2 for 4 cycles → in_ready drops while out_valid=1, then all 5 results emerge in order with no loss or duplication. Release out_ready together with in_valid → the simultaneous accept and consume succeeds.
